assoc_branch_predictor: RTL and testbench
=========================================

// Module: assoc_branch_predictor
// PURPOSE
//  Parametrised N-way set-associative branch direction predictor with tagged entries,
//  tree-PLRU replacement and CNT_WIDTH-bit saturating counters.
//  Lookup port (fetch stage) and update port (resolve stage) operate independently.
//  Lookup returns a registered prediction; a flush input invalidates all entries.
// PARAMETERS
//  PC_WIDTH   16  width of lookup_pc / upd_pc
//  INDEX_LEN  7   set index bits; SETS = 2**INDEX_LEN
//  TAG_LEN    7   tag bits; INDEX_LEN+TAG_LEN+2 <= PC_WIDTH (checked at elaboration)
//  WAYS       2   associativity; power of 2, range 1..8
//  CNT_WIDTH  2   saturating counter width, >= 2
// PORTS
//  clk         in   1          rising-edge clock
//  reset       in   1          synchronous, active-low reset
//  flush       in   1          invalidate all entries at next edge
//  lookup_valid in  1          lookup request this cycle
//  lookup_pc   in   PC_WIDTH   address to predict
//  pred_valid  out  1          prediction outputs valid (1 cycle after lookup_valid)
//  pred_hit    out  1          tag matched a valid way
//  pred_taken  out  1          predicted direction (counter MSB; 0 on miss)
//  pred_count  out  CNT_WIDTH  matched counter; 2**(CNT_WIDTH-1)-1 on miss
//  upd_valid   in   1          resolved-branch update this cycle
//  upd_pc      in   PC_WIDTH   address of resolved branch
//  upd_taken   in   1          actual outcome: 1 increment, 0 decrement
// BEHAVIOUR
//  - Address split: index = pc[INDEX_LEN+1:2]; tag = pc[INDEX_LEN+TAG_LEN+1:INDEX_LEN+2].
//  - Reset (reset==0 at edge): all valid bits 0, all PLRU bits 0, counters 2**(CNT_WIDTH-1)-1,
//    pred_valid/pred_hit/pred_taken 0, pred_count 0. Pending updates are dropped.
//  - Lookup: latency 1. pred_* registered from the state before the same edge's update.
//    lookup_valid==0 -> pred_valid 0; other pred_* hold their last values.
//    Lookups never change PLRU or counters.
//  - Update hit (valid way with equal tag in set): the counter saturates; it increments
//    toward 2**CNT_WIDTH-1 or decrements toward 0. PLRU is marked with the hit way as MRU.
//  - Update miss: victim = lowest-numbered invalid way; if none, the tree-PLRU victim.
//    Victim gets the tag and valid=1. Its counter is set to 2**(CNT_WIDTH-1) if upd_taken,
//    else 2**(CNT_WIDTH-1)-1. PLRU is marked with the victim as MRU.
//  - Tree-PLRU: WAYS-1 bits per set, heap-ordered (node n children 2n+1, 2n+2).
//    Bit 0 -> victim in lower half, bit 1 -> upper half.
//    On access, each node on the path is set to point away from the accessed way.
//    WAYS==1: no PLRU bits, victim always way 0.
//  - Lookup and update in the same cycle, same set: lookup sees pre-update contents
//    (read-before-write). No bypass.
//  - Priority at an edge: reset > flush > update. flush clears valid bits only.
//    PLRU and counters are unchanged; the update in that cycle is discarded.
//    A lookup in the flush cycle still returns pre-flush contents.
//  - Duplicate tags in one set never occur: a miss allocates only when no valid way matches.
//  - Storage is flops; update path is single-cycle, so back-to-back updates to the same
//    entry each take effect.
// TESTING
//  1. Release reset; lookup_pc=0x0104 -> next cycle pred_valid=1, hit=0, taken=0, count=2'b01.
//  2. upd 0x0104 taken=1, then lookup 0x0104 -> hit=1, count=2'b10, taken=1.
//  3. Saturation: 3 taken updates to 0x0104 -> count 2'b11, held.
//     Then 4 not-taken updates -> 2'b00, held.
//  4. WAYS=2, set 1: allocate tags A (0x0204), B (0x0404); update A; allocate C (0x0604).
//     Lookup B -> miss; A and C hit.
//  5. Same-cycle lookup+update of 0x0104 from count 2'b01, taken=1 -> pred_count=2'b01;
//     a lookup one cycle later -> 2'b10.
//  6. Flush asserted with upd_valid=1 (new pc 0x0808) -> all subsequent lookups miss,
//     including 0x0808. Reset mid-run -> pred_valid=0 and all entries miss.

Source files
------------

// File: rtl/assoc_branch_predictor.sv
// N-way set-associative branch direction predictor: tagged entries, tree-PLRU
// replacement, saturating counters, registered lookup and single-cycle update.
module assoc_branch_predictor #(
  parameter int PC_WIDTH  = 16,
  parameter int INDEX_LEN = 7,
  parameter int TAG_LEN   = 7,
  parameter int WAYS      = 2,
  parameter int CNT_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 lookup_valid,
  input  logic [PC_WIDTH-1:0]  lookup_pc,
  output logic                 pred_valid,
  output logic                 pred_hit,
  output logic                 pred_taken,
  output logic [CNT_WIDTH-1:0] pred_count,
  input  logic                 upd_valid,
  input  logic [PC_WIDTH-1:0]  upd_pc,
  input  logic                 upd_taken
);
  // lookup_valid and upd_valid are valid-only strobes: each is consumed in the
  // cycle it is high, there is no ready, and the predictor never stalls.
  localparam int SETS   = 1 << INDEX_LEN;
  localparam int LEVELS = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int NODES  = (WAYS > 1) ? WAYS - 1 : 1;
  localparam int WAY_W  = LEVELS;
  localparam logic [CNT_WIDTH-1:0] CNT_WEAK_NT = {1'b0, {(CNT_WIDTH-1){1'b1}}};
  localparam logic [CNT_WIDTH-1:0] CNT_WEAK_T  = {1'b1, {(CNT_WIDTH-1){1'b0}}};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX     = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO    = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE     = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  generate
    if (INDEX_LEN + TAG_LEN + 2 > PC_WIDTH) begin : g_bad_split
      $error("assoc_branch_predictor: INDEX_LEN+TAG_LEN+2 exceeds PC_WIDTH");
    end
    if (WAYS < 1 || WAYS > 8 || (WAYS & (WAYS - 1)) != 0) begin : g_bad_ways
      $error("assoc_branch_predictor: WAYS must be a power of 2 in 1..8");
    end
    if (CNT_WIDTH < 2) begin : g_bad_cnt
      $error("assoc_branch_predictor: CNT_WIDTH must be at least 2");
    end
  endgenerate

  logic [WAYS-1:0]      valid_q [SETS];
  logic [TAG_LEN-1:0]   tag_q   [SETS][WAYS];
  logic [CNT_WIDTH-1:0] cnt_q   [SETS][WAYS];
  logic [NODES-1:0]     plru_q  [SETS];

  // Walk the tree from the root; a 0 bit sends the victim into the lower half.
  function automatic logic [WAY_W-1:0] plru_victim(input logic [NODES-1:0] bits);
    logic [WAY_W-1:0] w;
    int n;
    w = '0;
    n = 0;
    if (WAYS > 1) begin
      for (int l = 0; l < LEVELS; l++) begin
        for (int k = 0; k < NODES; k++) if (k == n) w[LEVELS-1-l] = bits[k];
        n = 2 * n + 1 + int'(w[LEVELS-1-l]);
      end
    end
    return w;
  endfunction

  function automatic logic [NODES-1:0] plru_touch(input logic [NODES-1:0] bits,
                                                  input logic [WAY_W-1:0] way);
    logic [NODES-1:0] r;
    logic b;
    int n;
    r = bits;
    n = 0;
    if (WAYS > 1) begin
      for (int l = 0; l < LEVELS; l++) begin
        b = way[LEVELS-1-l];
        for (int k = 0; k < NODES; k++) if (k == n) r[k] = ~b;
        n = 2 * n + 1 + int'(b);
      end
    end
    return r;
  endfunction

  logic [INDEX_LEN-1:0] lk_idx, up_idx;
  logic [TAG_LEN-1:0]   lk_tag, up_tag;
  assign lk_idx = lookup_pc[INDEX_LEN+1:2];
  assign lk_tag = lookup_pc[INDEX_LEN+TAG_LEN+1:INDEX_LEN+2];
  assign up_idx = upd_pc[INDEX_LEN+1:2];
  assign up_tag = upd_pc[INDEX_LEN+TAG_LEN+1:INDEX_LEN+2];

  logic                 lk_hit;
  logic [CNT_WIDTH-1:0] lk_cnt;

  always_comb begin
    lk_hit = 1'b0;
    lk_cnt = CNT_WEAK_NT;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[lk_idx][w] && tag_q[lk_idx][w] == lk_tag) begin
        lk_hit = 1'b1;
        lk_cnt = cnt_q[lk_idx][w];
      end
    end
  end

  logic                 up_hit, up_free;
  logic [WAY_W-1:0]     up_hit_way, up_free_way, up_way;
  logic [CNT_WIDTH-1:0] up_cur_cnt, up_cnt_next;
  logic [NODES-1:0]     up_plru_next;

  always_comb begin
    up_hit      = 1'b0;
    up_hit_way  = '0;
    up_free     = 1'b0;
    up_free_way = '0;
    // Descending scan so the lowest-numbered invalid way is the one kept.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[up_idx][w]) begin
        up_free     = 1'b1;
        up_free_way = WAY_W'(w);
      end
      if (valid_q[up_idx][w] && tag_q[up_idx][w] == up_tag) begin
        up_hit     = 1'b1;
        up_hit_way = WAY_W'(w);
      end
    end
    up_cur_cnt = cnt_q[up_idx][up_hit_way];
    if (up_hit) begin
      up_way = up_hit_way;
      if (upd_taken) up_cnt_next = (up_cur_cnt == CNT_MAX) ? up_cur_cnt : up_cur_cnt + CNT_ONE;
      else           up_cnt_next = (up_cur_cnt == CNT_ZERO) ? up_cur_cnt : up_cur_cnt - CNT_ONE;
    end else begin
      up_way      = up_free ? up_free_way : plru_victim(plru_q[up_idx]);
      up_cnt_next = upd_taken ? CNT_WEAK_T : CNT_WEAK_NT;
    end
    up_plru_next = plru_touch(plru_q[up_idx], up_way);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        plru_q[s]  <= '0;
        for (int w = 0; w < WAYS; w++) begin
          tag_q[s][w] <= '0;
          cnt_q[s][w] <= CNT_WEAK_NT;
        end
      end
      pred_valid <= 1'b0;
      pred_hit   <= 1'b0;
      pred_taken <= 1'b0;
      pred_count <= '0;
    end else begin
      pred_valid <= lookup_valid;
      if (lookup_valid) begin
        pred_hit   <= lk_hit;
        pred_taken <= lk_cnt[CNT_WIDTH-1];
        pred_count <= lk_cnt;
      end
      // Flush drops only valid bits; the concurrent update is discarded.
      if (flush) begin
        for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
      end else if (upd_valid) begin
        valid_q[up_idx][up_way] <= 1'b1;
        tag_q[up_idx][up_way]   <= up_tag;
        cnt_q[up_idx][up_way]   <= up_cnt_next;
        plru_q[up_idx]          <= up_plru_next;
      end
    end
  end
endmodule

// File: tb/tb_assoc_branch_predictor.sv
// Self-checking bench for assoc_branch_predictor (default parameters, 2 ways):
// directed scenarios plus randomized traffic against a per-set LRU model.
module tb_assoc_branch_predictor;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        lookup_valid = 1'b0;
  logic [15:0] lookup_pc = '0;
  logic        pred_valid, pred_hit, pred_taken;
  logic [1:0]  pred_count;
  logic        upd_valid = 1'b0;
  logic [15:0] upd_pc = '0;
  logic        upd_taken = 1'b0;

  int errors = 0;
  int checks = 0;

  assoc_branch_predictor dut (
    .clk(clk), .reset(reset), .flush(flush),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .pred_valid(pred_valid), .pred_hit(pred_hit), .pred_taken(pred_taken),
    .pred_count(pred_count),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken)
  );

  always #5 clk = ~clk;

  // Reference model: 2 ways per set, with 2 ways the tree-PLRU equals true LRU.
  bit m_valid [128][2];
  int m_tag   [128][2];
  int m_cnt   [128][2];
  int m_lru   [128];
  bit exp_valid, exp_hit, exp_taken;
  int exp_count;
  logic [4:0] exp_q[$];

  function automatic int pc_idx(input logic [15:0] pc); return int'(pc[8:2]); endfunction
  function automatic int pc_tag(input logic [15:0] pc); return int'(pc[15:9]); endfunction

  task automatic model_reset();
    for (int s = 0; s < 128; s++) begin
      m_lru[s] = 0;
      for (int w = 0; w < 2; w++) begin m_valid[s][w] = 0; m_tag[s][w] = 0; m_cnt[s][w] = 1; end
    end
  endtask

  task automatic model_update(input logic [15:0] pc, input bit taken);
    int s, t, way;
    s = pc_idx(pc); t = pc_tag(pc); way = -1;
    for (int w = 0; w < 2; w++) if (m_valid[s][w] && m_tag[s][w] == t) way = w;
    if (way >= 0) begin
      if (taken) m_cnt[s][way] = (m_cnt[s][way] >= 3) ? 3 : m_cnt[s][way] + 1;
      else       m_cnt[s][way] = (m_cnt[s][way] <= 0) ? 0 : m_cnt[s][way] - 1;
    end else begin
      if (!m_valid[s][0]) way = 0;
      else if (!m_valid[s][1]) way = 1;
      else way = m_lru[s];
      m_valid[s][way] = 1; m_tag[s][way] = t;
      m_cnt[s][way] = taken ? 2 : 1;
    end
    m_lru[s] = 1 - way;
  endtask

  // One clock: drive inputs, predict the registered outputs, advance the model.
  task automatic step(input bit rst_n, input bit fl, input bit lv, input logic [15:0] lpc,
                      input bit uv, input logic [15:0] upc, input bit ut);
    int s, t;
    reset = rst_n; flush = fl; lookup_valid = lv; lookup_pc = lpc;
    upd_valid = uv; upd_pc = upc; upd_taken = ut;
    if (!rst_n) begin
      exp_valid = 0; exp_hit = 0; exp_taken = 0; exp_count = 0;
    end else begin
      exp_valid = lv;
      if (lv) begin
        s = pc_idx(lpc); t = pc_tag(lpc);
        exp_hit = 0; exp_count = 1;
        for (int w = 0; w < 2; w++)
          if (m_valid[s][w] && m_tag[s][w] == t) begin exp_hit = 1; exp_count = m_cnt[s][w]; end
        exp_taken = (exp_count >= 2);
      end
    end
    @(posedge clk); #1;
    if (!rst_n) model_reset();
    else if (fl) for (int k = 0; k < 128; k++) begin m_valid[k][0] = 0; m_valid[k][1] = 0; end
    else if (uv) model_update(upc, ut);
  endtask

  task automatic idle(); step(1, 0, 0, 16'h0, 0, 16'h0, 0); endtask
  task automatic lookup(input logic [15:0] pc); step(1, 0, 1, pc, 0, 16'h0, 0); endtask
  task automatic update(input logic [15:0] pc, input bit t); step(1, 0, 0, 16'h0, 1, pc, t); endtask

  task automatic test_reset();
    step(0, 0, 1, 16'h0104, 1, 16'h0104, 1);
    step(0, 0, 1, 16'h0104, 1, 16'h0104, 1);
    checks++; if (pred_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", pred_valid); end
    checks++; if (pred_hit !== 1'b0) begin errors++; $display("FAIL reset_hit got %b want 0", pred_hit); end
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL reset_taken got %b want 0", pred_taken); end
    checks++; if (pred_count !== 2'b00) begin errors++; $display("FAIL reset_count got %b want 00", pred_count); end
  endtask

  task automatic test_basic();
    lookup(16'h0104);
    checks++; if ({pred_valid, pred_hit, pred_taken, pred_count} !== 5'b10001) begin
      errors++; $display("FAIL cold_miss got v%b h%b t%b c%b want v1 h0 t0 c01", pred_valid, pred_hit, pred_taken, pred_count); end
    update(16'h0104, 1);
    lookup(16'h0104);
    checks++; if ({pred_valid, pred_hit, pred_taken, pred_count} !== 5'b11110) begin
      errors++; $display("FAIL alloc_taken got v%b h%b t%b c%b want v1 h1 t1 c10", pred_valid, pred_hit, pred_taken, pred_count); end
  endtask

  task automatic test_hold();
    idle();
    checks++; if ({pred_valid, pred_hit, pred_taken, pred_count} !== 5'b01110) begin
      errors++; $display("FAIL hold got v%b h%b t%b c%b want v0 h1 t1 c10", pred_valid, pred_hit, pred_taken, pred_count); end
  endtask

  task automatic test_saturation();
    repeat (3) update(16'h0104, 1);
    lookup(16'h0104);
    checks++; if (pred_count !== 2'b11) begin errors++; $display("FAIL sat_high got %b want 11", pred_count); end
    repeat (4) update(16'h0104, 0);
    lookup(16'h0104);
    checks++; if (pred_count !== 2'b00 || pred_taken !== 1'b0) begin
      errors++; $display("FAIL sat_low got c%b t%b want c00 t0", pred_count, pred_taken); end
  endtask

  task automatic test_replacement();
    update(16'h0204, 1);
    update(16'h0404, 0);
    update(16'h0204, 1);
    update(16'h0604, 1);
    lookup(16'h0404);
    checks++; if (pred_hit !== 1'b0 || pred_count !== 2'b01) begin
      errors++; $display("FAIL evict_B got h%b c%b want h0 c01", pred_hit, pred_count); end
    lookup(16'h0204);
    checks++; if (pred_hit !== 1'b1 || pred_count !== 2'b11) begin
      errors++; $display("FAIL keep_A got h%b c%b want h1 c11", pred_hit, pred_count); end
    lookup(16'h0604);
    checks++; if (pred_hit !== 1'b1 || pred_count !== 2'b10) begin
      errors++; $display("FAIL new_C got h%b c%b want h1 c10", pred_hit, pred_count); end
  endtask

  task automatic test_same_cycle();
    update(16'h0104, 1);
    step(1, 0, 1, 16'h0104, 1, 16'h0104, 1);
    checks++; if (pred_hit !== 1'b1 || pred_count !== 2'b01) begin
      errors++; $display("FAIL rbw_old got h%b c%b want h1 c01", pred_hit, pred_count); end
    lookup(16'h0104);
    checks++; if (pred_count !== 2'b10) begin errors++; $display("FAIL rbw_new got %b want 10", pred_count); end
  endtask

  task automatic test_back_to_back();
    update(16'h0104, 0);
    update(16'h0104, 0);
    lookup(16'h0104);
    checks++; if (pred_count !== 2'b00) begin errors++; $display("FAIL b2b_dec got %b want 00", pred_count); end
    update(16'h0104, 1);
    update(16'h0104, 1);
    update(16'h0104, 1);
    lookup(16'h0104);
    checks++; if (pred_count !== 2'b11) begin errors++; $display("FAIL b2b_inc got %b want 11", pred_count); end
  endtask

  task automatic test_flush();
    step(1, 1, 1, 16'h0104, 1, 16'h0808, 1);
    checks++; if (pred_hit !== 1'b1 || pred_count !== 2'b11) begin
      errors++; $display("FAIL flush_cycle got h%b c%b want h1 c11", pred_hit, pred_count); end
    lookup(16'h0104);
    checks++; if (pred_hit !== 1'b0 || pred_count !== 2'b01) begin
      errors++; $display("FAIL flush_old got h%b c%b want h0 c01", pred_hit, pred_count); end
    lookup(16'h0808);
    checks++; if (pred_hit !== 1'b0) begin errors++; $display("FAIL flush_dropped_upd got h%b want h0", pred_hit); end
    lookup(16'h0604);
    checks++; if (pred_hit !== 1'b0) begin errors++; $display("FAIL flush_other got h%b want h0", pred_hit); end
  endtask

  task automatic test_reset_mid();
    update(16'h0104, 1);
    update(16'h0A08, 0);
    step(0, 0, 1, 16'h0104, 0, 16'h0, 0);
    checks++; if (pred_valid !== 1'b0 || pred_count !== 2'b00) begin
      errors++; $display("FAIL midreset_out got v%b c%b want v0 c00", pred_valid, pred_count); end
    lookup(16'h0104);
    checks++; if (pred_valid !== 1'b1 || pred_hit !== 1'b0) begin
      errors++; $display("FAIL midreset_miss1 got v%b h%b want v1 h0", pred_valid, pred_hit); end
    lookup(16'h0A08);
    checks++; if (pred_hit !== 1'b0) begin errors++; $display("FAIL midreset_miss2 got h%b want h0", pred_hit); end
  endtask

  task automatic test_random();
    logic [15:0] lpc, upc;
    logic [4:0] exp;
    for (int i = 0; i < 400; i++) begin
      lpc = 16'(($urandom_range(0, 3) << 9) | ($urandom_range(1, 3) << 2));
      upc = 16'(($urandom_range(0, 3) << 9) | ($urandom_range(1, 3) << 2));
      step(1, ($urandom_range(0, 39) == 0), $urandom_range(0, 1) == 1, lpc,
           $urandom_range(0, 2) != 0, upc, $urandom_range(0, 1) == 1);
      exp_q.push_back({exp_valid, exp_hit, exp_taken, 2'(exp_count)});
      exp = exp_q.pop_front();
      checks++;
      if ({pred_valid, pred_hit, pred_taken, pred_count} !== exp) begin
        errors++;
        $display("FAIL random[%0d] got v%b h%b t%b c%b want %b", i, pred_valid, pred_hit, pred_taken, pred_count, exp);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_hold();
    test_saturation();
    test_replacement();
    test_same_cycle();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random();
    idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
